// File: rtl/alu_issue_stage_if.sv
// Request, ALU-facing and result signals of the ALU issue stage.
// The slave modport is the stage itself; master is the surrounding logic.
interface alu_issue_stage_if #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [2:0]       in_opcode;
    logic [TAG_W-1:0] in_tag;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_opcode;
    logic [31:0]      alu_result;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic [CNT_W-1:0] done_cnt;

    modport slave (
        input  in_valid, in_a, in_b, in_opcode, in_tag, alu_result, res_ready,
        output in_ready, alu_a, alu_b, alu_opcode,
               res_valid, res_data, res_tag, res_err, done_cnt
    );

    modport master (
        output in_valid, in_a, in_b, in_opcode, in_tag, alu_result, res_ready,
        input  in_ready, alu_a, alu_b, alu_opcode,
               res_valid, res_data, res_tag, res_err, done_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand FIFO feeding a combinational add/sub ALU; head-to-result latency 1 cycle.
// in_ready drops only when the FIFO is full; a stalled result freezes both result and FIFO.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    alu_issue_stage_if.slave  bus_io
);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

    logic [31:0]      a_mem   [DEPTH];
    logic [31:0]      b_mem   [DEPTH];
    logic [2:0]       op_mem  [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_err_q, res_err_d;
    logic [CNT_W-1:0] done_q, done_d;

    logic             empty, not_full, push, pop, head_legal;
    logic [2:0]       head_op;

    always_comb begin
        empty      = (cnt_q == '0);
        not_full   = (cnt_q != FULL);
        push       = bus_io.in_valid && not_full;
        pop        = !empty && (!res_valid_q || bus_io.res_ready);
        head_op    = empty ? 3'b000 : op_mem[rd_ptr_q];
        head_legal = (head_op == 3'b000) || (head_op == 3'b001);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        res_err_d   = res_err_q;
        if (pop) begin
            res_valid_d = 1'b1;
            res_data_d  = head_legal ? bus_io.alu_result : 32'd0;
            res_tag_d   = tag_mem[rd_ptr_q];
            res_err_d   = !head_legal;
        end else if (res_valid_q && bus_io.res_ready) begin
            res_valid_d = 1'b0;
        end

        done_d = (res_valid_q && bus_io.res_ready) ? done_q + 1'b1 : done_q;
    end

    // Payload storage needs no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_q]   <= bus_io.in_a;
            b_mem[wr_ptr_q]   <= bus_io.in_b;
            op_mem[wr_ptr_q]  <= bus_io.in_opcode;
            tag_mem[wr_ptr_q] <= bus_io.in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
            done_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            res_err_q   <= res_err_d;
            done_q      <= done_d;
        end
    end

    assign bus_io.in_ready   = not_full;
    assign bus_io.alu_a      = empty ? 32'd0 : a_mem[rd_ptr_q];
    assign bus_io.alu_b      = empty ? 32'd0 : b_mem[rd_ptr_q];
    assign bus_io.alu_opcode = head_op;
    assign bus_io.res_valid  = res_valid_q;
    assign bus_io.res_data   = res_data_q;
    assign bus_io.res_tag    = res_tag_q;
    assign bus_io.res_err    = res_err_q;
    assign bus_io.done_cnt   = done_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a 16-bit-counter instance plus a 4-bit-counter twin on the same stimulus.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_done = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.TAG_W(4), .CNT_W(16)) bus ();
    alu_issue_stage_if #(.TAG_W(4), .CNT_W(4))  bus4 ();

    alu_issue_stage #(.DEPTH(4), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus_io(bus.slave));
    alu_issue_stage #(.DEPTH(4), .TAG_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus_io(bus4.slave));

    // Reference ALU; unsupported opcodes give a nonzero junk value the stage must mask.
    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a + ~b + 32'd1;
            default: return a + b + 32'h55;
        endcase
    endfunction

    assign bus.alu_result  = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode);
    assign bus4.alu_result = alu_fn(bus4.alu_a, bus4.alu_b, bus4.alu_opcode);
    assign bus4.in_valid   = bus.in_valid;
    assign bus4.in_a       = bus.in_a;
    assign bus4.in_b       = bus.in_b;
    assign bus4.in_opcode  = bus.in_opcode;
    assign bus4.in_tag     = bus.in_tag;
    assign bus4.res_ready  = bus.res_ready;

    // Presents one request at a negedge, waits (bounded) for acceptance, returns at the following negedge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] tag);
        int n;
        n = 0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_opcode = op; bus.in_tag = tag;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept tag=%0d in_ready=%b required 1", tag, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 32'd0 || bus.res_tag !== 4'd0 ||
            bus.res_err !== 1'b0 || bus.done_cnt !== 16'd0 || bus.alu_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_state valid=%b data=%h tag=%h err=%b done=%0d alu_a=%h required all 0",
                     bus.res_valid, bus.res_data, bus.res_tag, bus.res_err, bus.done_cnt, bus.alu_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_stream();
        int r, first, last, nv;
        r = 0; first = -1; last = -1; nv = 0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (bus.res_valid === 1'b1) begin
                checks++;
                if (bus.res_tag !== 4'(r) || bus.res_data !== 32'(2 * r) || bus.res_err !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_result idx=%0d tag=%0d data=%0d required tag=%0d data=%0d",
                             r, bus.res_tag, bus.res_data, r % 16, 2 * r);
                end
                if (first < 0) first = c;
                last = c;
                nv++;
                r++;
            end
            if (c < 20) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_in_ready cycle=%0d got %b required 1", c, bus.in_ready);
                end
                bus.in_valid = 1'b1; bus.in_a = 32'(c); bus.in_b = 32'(c);
                bus.in_opcode = 3'b000; bus.in_tag = 4'(c);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        exp_done += 20;
        checks++;
        if (nv != 20 || last - first != 19) begin
            errors++;
            $display("FAIL stream_run valid_cycles=%0d span=%0d required 20 consecutive", nv, last - first + 1);
        end
        checks++;
        if (bus.done_cnt !== 16'(exp_done)) begin
            errors++;
            $display("FAIL stream_done_cnt got %0d required %0d", bus.done_cnt, exp_done);
        end
        checks++;
        if (bus4.done_cnt !== 4'd4) begin
            errors++;
            $display("FAIL stream_done_cnt_w4 got %0d required 4", bus4.done_cnt);
        end
    endtask

    task automatic test_single_add();
        bus.res_ready = 1'b1;
        send(32'd5, 32'd7, 3'b000, 4'd3);
        checks++;
        if (bus.res_valid !== 1'b0 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
            errors++;
            $display("FAIL add_head valid=%b alu_a=%0d alu_b=%0d required 0/5/7",
                     bus.res_valid, bus.alu_a, bus.alu_b);
        end
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd12 || bus.res_tag !== 4'd3 || bus.res_err !== 1'b0) begin
            errors++;
            $display("FAIL add_result valid=%b data=%0d tag=%0d err=%b required 1/12/3/0",
                     bus.res_valid, bus.res_data, bus.res_tag, bus.res_err);
        end
        @(negedge clk);
        exp_done += 1;
        checks++;
        if (bus.done_cnt !== 16'(exp_done) || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_done done=%0d valid=%b required %0d/0", bus.done_cnt, bus.res_valid, exp_done);
        end
    endtask

    task automatic test_sub_wrap();
        bus.res_ready = 1'b1;
        send(32'd0, 32'd1, 3'b001, 4'd4);
        @(negedge clk);
        checks++;
        if (bus.res_data !== 32'hFFFF_FFFF || bus.res_tag !== 4'd4 || bus.res_err !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap data=%h tag=%0d err=%b required ffffffff/4/0",
                     bus.res_data, bus.res_tag, bus.res_err);
        end
        @(negedge clk);
        send(32'hFFFF_FFFF, 32'd1, 3'b000, 4'd5);
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd0 || bus.res_tag !== 4'd5) begin
            errors++;
            $display("FAIL add_wrap valid=%b data=%h tag=%0d required 1/00000000/5",
                     bus.res_valid, bus.res_data, bus.res_tag);
        end
        @(negedge clk);
        exp_done += 2;
    endtask

    task automatic test_full();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'(i), 32'd10, 3'b000, 4'(i));
        bus.in_valid = 1'b1; bus.in_a = 32'd5; bus.in_b = 32'd10; bus.in_opcode = 3'b000; bus.in_tag = 4'd5;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_tag !== 4'd0 || bus.res_data !== 32'd10) begin
                errors++;
                $display("FAIL full_hold cycle=%0d in_ready=%b valid=%b tag=%0d data=%0d required 0/1/0/10",
                         k, bus.in_ready, bus.res_valid, bus.res_tag, bus.res_data);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'(i) || bus.res_data !== 32'(i + 10)) begin
                errors++;
                $display("FAIL full_drain idx=%0d valid=%b tag=%0d data=%0d required 1/%0d/%0d",
                         i, bus.res_valid, bus.res_tag, bus.res_data, i, i + 10);
            end
            @(negedge clk);
        end
        exp_done += 5;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.done_cnt !== 16'(exp_done)) begin
            errors++;
            $display("FAIL full_after valid=%b in_ready=%b done=%0d required 0/1/%0d",
                     bus.res_valid, bus.in_ready, bus.done_cnt, exp_done);
        end
    endtask

    task automatic test_illegal();
        bus.res_ready = 1'b1;
        send(32'd9, 32'd9, 3'b101, 4'd7);
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd0 || bus.res_err !== 1'b1 || bus.res_tag !== 4'd7) begin
            errors++;
            $display("FAIL illegal_op valid=%b data=%0d err=%b tag=%0d required 1/0/1/7",
                     bus.res_valid, bus.res_data, bus.res_err, bus.res_tag);
        end
        @(negedge clk);
        send(32'd2, 32'd3, 3'b000, 4'd8);
        @(negedge clk);
        checks++;
        if (bus.res_data !== 32'd5 || bus.res_err !== 1'b0 || bus.res_tag !== 4'd8) begin
            errors++;
            $display("FAIL legal_after_illegal data=%0d err=%b tag=%0d required 5/0/8",
                     bus.res_data, bus.res_err, bus.res_tag);
        end
        @(negedge clk);
        exp_done += 2;
    endtask

    task automatic test_reset_mid();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(100 + i), 32'd1, 3'b001, 4'(9 + i));
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd99 || bus.alu_a !== 32'd101) begin
            errors++;
            $display("FAIL midreset_pre valid=%b data=%0d alu_a=%0d required 1/99/101",
                     bus.res_valid, bus.res_data, bus.alu_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 32'd0 || bus.res_tag !== 4'd0 || bus.res_err !== 1'b0 ||
            bus.done_cnt !== 16'd0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
            errors++;
            $display("FAIL midreset_clear valid=%b data=%0d tag=%0d err=%b done=%0d alu_a=%0d alu_b=%0d required all 0",
                     bus.res_valid, bus.res_data, bus.res_tag, bus.res_err, bus.done_cnt, bus.alu_a, bus.alu_b);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_done = 0;
        bus.res_ready = 1'b1;
        send(32'd20, 32'd22, 3'b000, 4'd2);
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd42 || bus.res_tag !== 4'd2) begin
            errors++;
            $display("FAIL midreset_after valid=%b data=%0d tag=%0d required 1/42/2",
                     bus.res_valid, bus.res_data, bus.res_tag);
        end
        @(negedge clk);
        checks++;
        if (bus.done_cnt !== 16'd1 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_done done=%0d valid=%b required 1/0", bus.done_cnt, bus.res_valid);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_opcode = '0; bus.in_tag = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_stream();
        test_single_add();
        test_sub_wrap();
        test_full();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Operand issue stage directly upstream of the 32-bit add/sub ALU. It accepts operation requests (A, B, opcode, tag) over a valid/ready handshake and buffers them in a small FIFO. It presents the head entry combinationally to the ALU and captures the ALU result, with tag and error status, into an output register using a valid/ready handshake. It also keeps a wrapping count of completed operations.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
TAG_W, 4, width of the request tag carried alongside each operation
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  stage can accept a request
in_a  input  32  operand A
in_b  input  32  operand B
in_opcode  input  3  ALU opcode
in_tag  input  TAG_W  request tag
alu_a  output  32  head-entry A to ALU (combinational from FIFO head)
alu_b  output  32  head-entry B to ALU
alu_opcode  output  3  head-entry opcode to ALU
alu_result  input  32  combinational ALU result for alu_a/alu_b/alu_opcode
res_valid  output  1  registered result valid
res_ready  input  1  downstream accepts result
res_data  output  32  registered result
res_tag  output  TAG_W  tag of the result
res_err  output  1  result came from an unsupported opcode
done_cnt  output  CNT_W  completed (res handshake) operations, wraps

Behaviour:
- Reset (asynchronous, takes effect immediately): FIFO emptied (read ptr, write ptr, count = 0); res_valid=0, res_data=0, res_tag=0, res_err=0, done_cnt=0. in_ready=1 once rst is deasserted. Reset mid-operation discards all buffered and pending entries; there is no partial completion.
- FIFO: push on in_valid && in_ready. in_ready = (count != DEPTH). There is no bypass when full: a push and a pop in the same cycle while full is not possible, because in_ready=0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits; push+pop in the same cycle leaves it unchanged.
- FIFO empty: alu_a, alu_b and alu_opcode are driven to 0. The ALU output is ignored.
- Output register load condition: load = (count != 0) && (!res_valid || res_ready). On load:
  - pop the head;
  - res_data = alu_result if head opcode is 000 or 001, else 0;
  - res_err = 1 if head opcode is not in {000, 001};
  - res_tag = head tag;
  - res_valid = 1.
- If res_valid && res_ready && !load, res_valid -> 0. res_data, res_tag and res_err hold their last values.
- When res_valid=1 and res_ready=0, the result and the FIFO are both held stable.
- Latency: a request accepted at edge k, into an empty FIFO with the output register free, gives res_valid=1 after edge k+1.
- Sustained throughput is 1 op/cycle while res_ready=1 and requests keep arriving.
- Ordering is strict FIFO; results leave in acceptance order.
- done_cnt increments by 1 on each res_valid && res_ready cycle and wraps from 2^CNT_W-1 to 0.
- Arithmetic is the ALU's: 32-bit modulo 2^32; subtraction is A + ~B + 1. The stage does not alter the data.

Test Plan:
- Single add: A=5, B=7, op=000, tag=3, res_ready=1 -> res_valid one cycle after acceptance, res_data=12, res_tag=3, res_err=0, done_cnt=1.
- Subtract wrap: A=0, B=1, op=001 -> res_data=32'hFFFFFFFF; A=32'hFFFFFFFF, B=1, op=000 -> res_data=0.
- Backpressure/full: res_ready=0, push 6 requests with tags 0..5 -> one held in the output register, 4 in the FIFO, in_ready=0. Release res_ready -> tags emerge 0..4 in order, with no loss or duplication.
- Illegal opcode: op=101, A=9, B=9 -> res_data=0, res_err=1, tag preserved. The next op=000 result has res_err=0.
- Streaming: 20 back-to-back requests with res_ready=1 -> 20 consecutive res_valid cycles, done_cnt=20. Set CNT_W=4 -> done_cnt=4 after 20 results.
- Reset mid-flight: assert rst with 3 entries queued and res_valid=1 -> all outputs go to 0 immediately. After release, a new request completes normally with done_cnt=1.
